// File: rtl/ps2_mouse_packet_decoder_pkg.sv
// Shared types and constants for the PS/2 mouse packet decoder.
// Byte-0 bit map, FSM states and the motion magnitude helper.
package ps2_mouse_pkg;

  typedef enum logic [2:0] {
    B0,
    B1,
    B2,
    B3,
    DONE
  } state_e;

  localparam int BTN_L    = 0;
  localparam int BTN_R    = 1;
  localparam int BTN_M    = 2;
  localparam int SYNC_BIT = 3;
  localparam int XS       = 4;
  localparam int YS       = 5;
  localparam int XO       = 6;
  localparam int YO       = 7;

  localparam logic [8:0] MAG_SAT = 9'd256;

  // |{s,b}| on 9 bits; -256 maps to 256, overflow saturates
  function automatic logic [8:0] mag9(
    input logic       s,
    input logic       ovf,
    input logic [7:0] b
  );
    logic [8:0] d;
    d = {s, b};
    if (ovf) return MAG_SAT;
    return s ? (~d + 9'd1) : d;
  endfunction

endpackage

// File: rtl/ps2_mouse_packet_decoder_if.sv
// Byte-stream input and decoded-packet output bundle.
// master drives bytes, slave is the decoder.
interface ps2_mouse_packet_decoder_if #(
  parameter int VEL_W = 10
);
  logic             byte_ready;
  logic [7:0]       byte_data;
  logic             pkt_valid;
  logic [2:0]       buttons;
  logic [8:0]       dx;
  logic [8:0]       dy;
  logic [3:0]       wheel;
  logic             x_ovf;
  logic             y_ovf;
  logic [VEL_W-1:0] vx;
  logic [VEL_W-1:0] vy;
  logic             dir_x;
  logic             dir_y;
  logic             sync_err;
  logic             timeout;

  modport master (
    output byte_ready, byte_data,
    input  pkt_valid, buttons, dx, dy, wheel,
    input  x_ovf, y_ovf, vx, vy, dir_x, dir_y,
    input  sync_err, timeout
  );

  modport slave (
    input  byte_ready, byte_data,
    output pkt_valid, buttons, dx, dy, wheel,
    output x_ovf, y_ovf, vx, vy, dir_x, dir_y,
    output sync_err, timeout
  );
endinterface

// File: rtl/ps2_mouse_packet_decoder_edge.sv
// Two-flop sampler with rising-edge detect for a slow level.
// Reusable for any level that crosses into clk.
module ps2_edge_sync (
  input  logic clk,
  input  logic rstn,
  input  logic lvl_i,
  output logic rise_o
);
  logic [1:0] smp_q;

  // shift the level through the sampler
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) smp_q <= 2'b00;
    else       smp_q <= {smp_q[0], lvl_i};
  end

  assign rise_o = smp_q[0] & ~smp_q[1];
endmodule

// File: rtl/ps2_mouse_packet_decoder.sv
// PS/2 mouse packet assembler and decoder.
// 3- or 4-byte packets, partial-packet timeout, stale-motion clear.
module ps2_mouse_packet_decoder
  import ps2_mouse_pkg::*;
#(
  parameter int PKT_BYTES      = 3,
  parameter int TIMEOUT_CYCLES = 10_000_000,
  parameter int VEL_SHIFT      = 1,
  parameter int VEL_W          = 10
) (
  input logic clk,
  input logic rstn,
  ps2_mouse_packet_decoder_if.slave bus
);
  localparam int CW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX =
    CW'(TIMEOUT_CYCLES - 1);

  logic       ev;
  logic [7:0] byte_i;

  state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0] b0_q, b0_d;
  logic [7:0] b1_q, b1_d;
  logic [7:0] b2_q, b2_d;

  logic       pkt_q, pkt_d;
  logic       serr_q, serr_d;
  logic       tout_q, tout_d;
  logic [2:0] btn_q, btn_d;
  logic [8:0] dx_q, dx_d;
  logic [8:0] dy_q, dy_d;
  logic [3:0] wh_q, wh_d;
  logic       xo_q, xo_d;
  logic       yo_q, yo_d;
  logic [VEL_W-1:0] vx_q, vx_d;
  logic [VEL_W-1:0] vy_q, vy_d;
  logic       dirx_q, dirx_d;
  logic       diry_q, diry_d;

  logic       expd;
  logic       dec_en;
  logic       stale;
  logic       idle;
  logic [7:0] fb2;
  logic [8:0] mag_x;
  logic [8:0] mag_y;
  logic [8:0] shx;
  logic [8:0] shy;

  ps2_edge_sync u_sync (
    .clk    (clk),
    .rstn   (rstn),
    .lvl_i  (bus.byte_ready),
    .rise_o (ev)
  );

  assign byte_i = bus.byte_data;
  assign expd   = (cnt_q == CNT_MAX);

  // last data byte arrives live when the packet ends in B2
  assign fb2   = (state_q == B2) ? byte_i : b2_q;
  assign mag_x = mag9(b0_q[XS], b0_q[XO], b1_q);
  assign mag_y = mag9(b0_q[YS], b0_q[YO], fb2);
  assign shx   = mag_x >> VEL_SHIFT;
  assign shy   = mag_y >> VEL_SHIFT;

  // FSM next state, byte capture and shared idle counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    b0_d    = b0_q;
    b1_d    = b1_q;
    b2_d    = b2_q;
    serr_d  = 1'b0;
    tout_d  = 1'b0;
    dec_en  = 1'b0;
    stale   = 1'b0;
    idle    = 1'b0;
    unique case (state_q)
      B0: begin
        if (ev && byte_i[SYNC_BIT]) begin
          b0_d    = byte_i;
          cnt_d   = '0;
          state_d = B1;
        end else begin
          serr_d = ev;
          if (expd) stale = 1'b1;
          else      cnt_d = cnt_q + CW'(1);
        end
      end
      B1: begin
        if (ev) begin
          b1_d    = byte_i;
          cnt_d   = '0;
          state_d = b0_q[SYNC_BIT] ? B2 : B0;
        end else begin
          idle = 1'b1;
        end
      end
      B2: begin
        if (ev) begin
          b2_d  = byte_i;
          cnt_d = '0;
          if (PKT_BYTES == 4) begin
            state_d = B3;
          end else begin
            dec_en  = 1'b1;
            state_d = DONE;
          end
        end else begin
          idle = 1'b1;
        end
      end
      B3: begin
        if (ev) begin
          cnt_d   = '0;
          dec_en  = 1'b1;
          state_d = DONE;
        end else begin
          idle = 1'b1;
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = B0;
      end
      default: state_d = B0;
    endcase
    if (idle) begin
      if (expd) begin
        state_d = B0;
        cnt_d   = '0;
        tout_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // decoded outputs: load on packet end, clear motion when stale
  always_comb begin
    pkt_d  = dec_en;
    btn_d  = btn_q;
    dx_d   = dx_q;
    dy_d   = dy_q;
    wh_d   = wh_q;
    xo_d   = xo_q;
    yo_d   = yo_q;
    vx_d   = vx_q;
    vy_d   = vy_q;
    dirx_d = dirx_q;
    diry_d = diry_q;
    if (dec_en) begin
      btn_d  = {b0_q[BTN_M], b0_q[BTN_R], b0_q[BTN_L]};
      dx_d   = {b0_q[XS], b1_q};
      dy_d   = {b0_q[YS], fb2};
      wh_d   = (PKT_BYTES == 4) ? byte_i[3:0] : 4'd0;
      xo_d   = b0_q[XO];
      yo_d   = b0_q[YO];
      vx_d   = VEL_W'(shx);
      vy_d   = VEL_W'(shy);
      dirx_d = ~b0_q[XS];
      diry_d = ~b0_q[YS];
    end else if (stale) begin
      dx_d = '0;
      dy_d = '0;
      wh_d = '0;
      vx_d = '0;
      vy_d = '0;
    end
  end

  // FSM, counter and byte registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= B0;
      cnt_q   <= '0;
      b0_q    <= '0;
      b1_q    <= '0;
      b2_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      b0_q    <= b0_d;
      b1_q    <= b1_d;
      b2_q    <= b2_d;
    end
  end

  // output registers and status pulses
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pkt_q  <= 1'b0;
      serr_q <= 1'b0;
      tout_q <= 1'b0;
      btn_q  <= '0;
      dx_q   <= '0;
      dy_q   <= '0;
      wh_q   <= '0;
      xo_q   <= 1'b0;
      yo_q   <= 1'b0;
      vx_q   <= '0;
      vy_q   <= '0;
      dirx_q <= 1'b0;
      diry_q <= 1'b0;
    end else begin
      pkt_q  <= pkt_d;
      serr_q <= serr_d;
      tout_q <= tout_d;
      btn_q  <= btn_d;
      dx_q   <= dx_d;
      dy_q   <= dy_d;
      wh_q   <= wh_d;
      xo_q   <= xo_d;
      yo_q   <= yo_d;
      vx_q   <= vx_d;
      vy_q   <= vy_d;
      dirx_q <= dirx_d;
      diry_q <= diry_d;
    end
  end

  assign bus.pkt_valid = pkt_q;
  assign bus.sync_err  = serr_q;
  assign bus.timeout   = tout_q;
  assign bus.buttons   = btn_q;
  assign bus.dx        = dx_q;
  assign bus.dy        = dy_q;
  assign bus.wheel     = wh_q;
  assign bus.x_ovf     = xo_q;
  assign bus.y_ovf     = yo_q;
  assign bus.vx        = vx_q;
  assign bus.vy        = vy_q;
  assign bus.dir_x     = dirx_q;
  assign bus.dir_y     = diry_q;
endmodule

// File: tb/tb_ps2_mouse_packet_decoder.sv
// Scoreboard bench for ps2_mouse_packet_decoder.
// One 3-byte and one 4-byte instance, short timeout.
module tb_ps2_mouse_packet_decoder;
  localparam int TO = 64;

  typedef struct packed {
    logic [2:0]  kind;
    logic [48:0] f;
  } exp_t;

  localparam logic [2:0] K_PKT = 3'b100;
  localparam logic [2:0] K_SER = 3'b010;
  localparam logic [2:0] K_TO  = 3'b001;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   n_tot = 0;
  int   n_pass = 0;
  exp_t q3[$];
  exp_t q4[$];

  always #5 clk = ~clk;

  ps2_mouse_packet_decoder_if #(.VEL_W(10)) i3();
  ps2_mouse_packet_decoder_if #(.VEL_W(10)) i4();

  ps2_mouse_packet_decoder #(
    .PKT_BYTES(3), .TIMEOUT_CYCLES(TO),
    .VEL_SHIFT(1), .VEL_W(10)
  ) u3 (.clk(clk), .rstn(rstn), .bus(i3));

  ps2_mouse_packet_decoder #(
    .PKT_BYTES(4), .TIMEOUT_CYCLES(TO),
    .VEL_SHIFT(1), .VEL_W(10)
  ) u4 (.clk(clk), .rstn(rstn), .bus(i4));

  logic [48:0] f3, f4;
  assign f3 = {i3.buttons, i3.dx, i3.dy, i3.wheel,
               i3.x_ovf, i3.y_ovf, i3.vx, i3.vy,
               i3.dir_x, i3.dir_y};
  assign f4 = {i4.buttons, i4.dx, i4.dy, i4.wheel,
               i4.x_ovf, i4.y_ovf, i4.vx, i4.vy,
               i4.dir_x, i4.dir_y};

  task automatic chk(input string n,
                     input logic [63:0] a,
                     input logic [63:0] e);
    n_tot++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %0h want %0h", n, a, e);
  endtask

  function automatic logic [48:0] mk(
    input logic [2:0] btn,
    input logic [8:0] dx, input logic [8:0] dy,
    input logic [3:0] wh,
    input logic xo, input logic yo,
    input logic [9:0] vx, input logic [9:0] vy,
    input logic drx, input logic dry);
    return {btn, dx, dy, wh, xo, yo, vx, vy, drx, dry};
  endfunction

  task automatic push(input int id, input logic [2:0] k,
                      input logic [48:0] f);
    exp_t e;
    e.kind = k;
    e.f    = f;
    if (id == 3) q3.push_back(e);
    else         q4.push_back(e);
  endtask

  task automatic send(input int id, input logic [7:0] b);
    @(posedge clk); #1;
    if (id == 3) begin
      i3.byte_data = b; i3.byte_ready = 1'b1;
    end else begin
      i4.byte_data = b; i4.byte_ready = 1'b1;
    end
    repeat (4) @(posedge clk); #1;
    i3.byte_ready = 1'b0;
    i4.byte_ready = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  // monitor for the 3-byte instance
  always @(negedge clk) begin
    if (rstn && (i3.pkt_valid || i3.sync_err || i3.timeout)) begin
      if (q3.size() == 0) begin
        chk("u3_extra_event",
            {i3.pkt_valid, i3.sync_err, i3.timeout}, 0);
      end else begin
        exp_t e;
        e = q3.pop_front();
        chk("u3_kind",
            {i3.pkt_valid, i3.sync_err, i3.timeout}, e.kind);
        if (e.kind == K_PKT) chk("u3_fields", f3, e.f);
      end
    end
  end

  // monitor for the 4-byte instance
  always @(negedge clk) begin
    if (rstn && (i4.pkt_valid || i4.sync_err || i4.timeout)) begin
      if (q4.size() == 0) begin
        chk("u4_extra_event",
            {i4.pkt_valid, i4.sync_err, i4.timeout}, 0);
      end else begin
        exp_t e;
        e = q4.pop_front();
        chk("u4_kind",
            {i4.pkt_valid, i4.sync_err, i4.timeout}, e.kind);
        if (e.kind == K_PKT) chk("u4_fields", f4, e.f);
      end
    end
  end

  initial begin
    i3.byte_ready = 1'b0; i3.byte_data = 8'h00;
    i4.byte_ready = 1'b0; i4.byte_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_u3", {f3, i3.pkt_valid, i3.sync_err, i3.timeout}, 0);
    chk("rst_u4", {f4, i4.pkt_valid, i4.sync_err, i4.timeout}, 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    repeat (4) @(posedge clk);

    // 0x29,05,FB: +5 / -5
    push(3, K_PKT, mk(3'b001, 9'h005, 9'h1FB, 4'h0, 0, 0,
                      10'd2, 10'd2, 1, 0));
    send(3, 8'h29); send(3, 8'h05); send(3, 8'hFB);

    // 0x09,05,FB: +5 / +251
    push(3, K_PKT, mk(3'b001, 9'h005, 9'h0FB, 4'h0, 0, 0,
                      10'd2, 10'd125, 1, 1));
    send(3, 8'h09); send(3, 8'h05); send(3, 8'hFB);

    // bad sync byte, then -128 / 0
    push(3, K_SER, '0);
    push(3, K_PKT, mk(3'b011, 9'h180, 9'h000, 4'h0, 0, 0,
                      10'd64, 10'd0, 0, 1));
    send(3, 8'h00);
    send(3, 8'h1B); send(3, 8'h80); send(3, 8'h00);

    // partial packet abandoned, then fresh packet
    push(3, K_TO, '0);
    send(3, 8'h09); send(3, 8'h10);
    repeat (100) @(posedge clk);
    push(3, K_PKT, mk(3'b100, 9'h002, 9'h003, 4'h0, 0, 0,
                      10'd1, 10'd1, 1, 1));
    send(3, 8'h0C); send(3, 8'h02); send(3, 8'h03);

    // motion held briefly, then stale clear
    @(negedge clk);
    chk("held_motion", {i3.dx, i3.vx, i3.vy}, {9'h002, 10'd1, 10'd1});
    repeat (100) @(negedge clk);
    chk("stale_motion",
        {i3.dx, i3.dy, i3.wheel, i3.vx, i3.vy}, 0);
    chk("stale_hold", {i3.buttons, i3.dir_x, i3.dir_y},
        {3'b100, 1'b1, 1'b1});

    // reset between byte 1 and byte 2
    send(3, 8'h09); send(3, 8'h05);
    @(posedge clk); #1;
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_u3", {f3, i3.pkt_valid, i3.sync_err, i3.timeout}, 0);
    chk("midrst_u4", {f4, i4.pkt_valid, i4.sync_err, i4.timeout}, 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    repeat (2) @(posedge clk);
    push(3, K_PKT, mk(3'b001, 9'h007, 9'h001, 4'h0, 0, 0,
                      10'd3, 10'd0, 1, 1));
    send(3, 8'h09); send(3, 8'h07); send(3, 8'h01);

    // 4-byte: x overflow saturates, wheel -1
    push(4, K_PKT, mk(3'b000, 9'h000, 9'h000, 4'hF, 1, 0,
                      10'd128, 10'd0, 1, 1));
    send(4, 8'h48); send(4, 8'h00); send(4, 8'h00);
    send(4, 8'h0F);

    // 4-byte: dx=-256, y overflow, all buttons
    push(4, K_PKT, mk(3'b111, 9'h100, 9'h07F, 4'h7, 0, 1,
                      10'd128, 10'd128, 0, 1));
    send(4, 8'h9F); send(4, 8'h00); send(4, 8'h7F);
    send(4, 8'h07);

    repeat (10) @(posedge clk);
    chk("u3_all_seen", 64'(q3.size()), 0);
    chk("u4_all_seen", 64'(q4.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
